seq_mult_ctrl: RTL and testbench
================================

Name: seq_mult_ctrl

Overview:
Sequential shift-add multiplier that time-shares a single N-bit row of multiplier cells across N cycles, instead of the full N×N combinational array. It accepts an operand pair on a valid/ready handshake and steps the cell row once per clock, one multiplier bit per step. It then presents the 2N-bit product on a valid/ready output handshake. It sits between the operand source and the consumer, and replaces the array multiplier where area matters more than latency.

Parameters:
N, 8, operand width in bits; legal range 2..32
CW, $clog2(N), step-counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
inValid  input  1  operand pair present
inReady  output  1  block can accept operands
multiplicand  input  N  unsigned operand A
multiplier  input  N  unsigned operand B
outValid  output  1  product valid
outReady  input  1  consumer accepts product
product  output  2N  unsigned A*B
busy  output  1  high in RUN state

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high; on any clk edge with reset=1:
  - state=IDLE, count=0, accumulator ACC(2N)=0, A register=0
  - outputs: inReady=1 (from the cycle after), outValid=0, busy=0, product=0
- Reset has priority over every other event, including mid-RUN and in DONE with the product held.
- FSM IDLE:
  - inReady=1.
  - On an edge with inValid=1: A<=multiplicand, ACC<={N'b0, multiplier}, count<=0, go to RUN.
  - inValid=0: stay in IDLE.
- FSM RUN:
  - inReady=0, busy=1.
  - Each edge: row computes {c, S} = ACC[2N-1:N] + (A & {N{ACC[0]}}), then ACC <= {c, S, ACC[N-1:1]} and count<=count+1.
  - On the edge where count==N-1, go to DONE.
  - Exactly N RUN edges follow the accept edge.
  - inValid is ignored throughout RUN; operand ports may change freely.
- FSM DONE:
  - outValid=1, product=ACC, inReady=0.
  - On an edge with outReady=1: go to IDLE; ACC is retained but outValid drops.
  - outReady=0: hold state and product stable indefinitely.
- Latency: outValid rises after the N-th edge following the accept edge. Minimum initiation interval is N+2 cycles (accept, N steps, handshake).
- Width rules: product is exact with no truncation; the row carry-out fills bit 2N-1 on each shift, so max×max = (2^N−1)² is correct.
- Boundary conditions:
  - Multiplier=0 or multiplicand=0 still takes the full N steps and yields 0.
  - count must not wrap past N-1 inside RUN.
  - inValid and outReady may both be high in DONE; only outReady acts, and the new operand is taken in IDLE the following cycle.
- Timing: the cell row is combinational with gate delays. The bench clock period must exceed the row ripple settle time (100 time units at N=8).

Decomposition:
- Package mult_pkg:
  - state enum {IDLE, RUN, DONE} (2-bit)
  - default width constant MULT_N=8
- Sub-module mult_row:
  - N existing multiplier cells chained carry-to-carry, carryIn of bit 0 tied to 0
  - ppBitIn ← ACC upper half, multiplicandBit ← A[i], multiplierBit ← ACC[0]
  - outputs sum[N-1:0] and the final carryOut
- seq_mult_ctrl holds the FSM, counter, registers and handshake only.

Test Plan:
- reset, then A=13, B=11, inValid 1 cycle, outReady=1 → inReady drops next cycle; outValid rises exactly 8 edges after accept; product=143; back to IDLE one cycle later.
- A=255, B=255 → product=65025 (16'hFE01); A=0, B=200 → 0 after the full 8 steps; A=1, B=128 → 128.
- Backpressure: A=6, B=7 with outReady=0 for 5 cycles after outValid → product stays 42 and outValid stays 1; outReady=1 → outValid=0 next cycle.
- Ignore while busy: A=3, B=5 accepted; at step 4 drive inValid=1 with A=9, B=9 → inReady stays 0; product=15; the 9×9 pair is taken only if still asserted in IDLE.
- Reset mid-RUN: A=100, B=100, assert reset at step 3 → next cycle state=IDLE, outValid=0, product=0, inReady=1; new A=2, B=3 → 6.
- Back-to-back: 50 random pairs with random outReady stalls → each product matches A*B against a reference model; no outValid without a prior accept.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   MULT_N     default operand width
//   multState  controller state encoding
package mult_pkg;

   localparam int unsigned MULT_N = 8;

   typedef enum logic [1:0] {
      Idle = 2'd0,
      Run  = 2'd1,
      Done = 2'd2
   } multState;

endpackage

// File: rtl/seq_mult_ctrl_if.sv
// Operand / product handshake bundle for seq_mult_ctrl.
//   inValid, multiplicand, multiplier  operand pair offered by the source
//   inReady                            block can take an operand pair
//   outValid, product                  product offered to the consumer
//   outReady                           consumer takes the product
// master: operand source + product consumer; slave: the multiplier.
interface seq_mult_ctrl_if
   import mult_pkg::*;
#(
   parameter int unsigned N = MULT_N
);

   logic             inValid;
   logic             inReady;
   logic [N-1:0]     multiplicand;
   logic [N-1:0]     multiplier;
   logic             outValid;
   logic             outReady;
   logic [2*N-1:0]   product;

   modport master (
      output inValid, multiplicand, multiplier, outReady,
      input  inReady, outValid, product
   );

   modport slave (
      input  inValid, multiplicand, multiplier, outReady,
      output inReady, outValid, product
   );

endinterface

// File: rtl/mult_row.sv
// One row of N multiplier cells chained carry-to-carry (carry into bit 0 is 0).
// Each cell adds the partial-product bit (multiplicandBit[i] & multiplierBit)
// to ppBitIn[i] with the ripple carry.
//   ppBitIn          upper half of the accumulator
//   multiplicandBit  operand A
//   multiplierBit    current multiplier bit (accumulator LSB)
//   sum              row sum, N bits
//   carryOut         carry out of the last cell
module mult_row
   import mult_pkg::*;
#(
   parameter int unsigned N = MULT_N
) (
   input  logic [N-1:0] ppBitIn,
   input  logic [N-1:0] multiplicandBit,
   input  logic         multiplierBit,
   output logic [N-1:0] sum,
   output logic         carryOut
);

   // Ripple through the cells in one process so the carry chain is a
   // single combinational path rather than a self-referencing vector.
   always_comb begin
      logic c;
      logic pp;
      c   = 1'b0;
      pp  = 1'b0;
      sum = '0;
      for (int i = 0; i < int'(N); i++) begin
         pp     = multiplicandBit[i] & multiplierBit;
         sum[i] = ppBitIn[i] ^ pp ^ c;
         c      = (ppBitIn[i] & pp) | (c & (ppBitIn[i] ^ pp));
      end
      carryOut = c;
   end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential shift-add multiplier controller. Takes an operand pair, steps a
// single mult_row once per clock for N clocks, then offers the 2N-bit product.
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    operand/product handshake (slave side)
//   busy   high while stepping
module seq_mult_ctrl
   import mult_pkg::*;
#(
   parameter int unsigned N = MULT_N
) (
   input  logic            clk,
   input  logic            reset,
   seq_mult_ctrl_if.slave  bus,
   output logic            busy
);

   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   multState          stateQ, stateD;
   logic [CW-1:0]     countQ, countD;
   logic [2*N-1:0]    accQ, accD;
   logic [N-1:0]      aQ, aD;
   logic [N-1:0]      rowSum;
   logic              rowCarry;

   mult_row #(
      .N (N)
   ) uRow (
      .ppBitIn         (accQ[2*N-1:N]),
      .multiplicandBit (aQ),
      .multiplierBit   (accQ[0]),
      .sum             (rowSum),
      .carryOut        (rowCarry)
   );

   always_comb begin
      stateD = stateQ;
      countD = countQ;
      accD   = accQ;
      aD     = aQ;
      unique case (stateQ)
         Idle: begin
            if (bus.inValid) begin
               aD     = bus.multiplicand;
               accD   = {{N{1'b0}}, bus.multiplier};
               countD = '0;
               stateD = Run;
            end
         end
         Run: begin
            // Row carry refills the top bit, so the product never truncates.
            accD = {rowCarry, rowSum, accQ[N-1:1]};
            if (countQ == CW'(N - 1)) begin
               // Hold at N-1 instead of wrapping.
               stateD = Done;
            end else begin
               countD = countQ + CW'(1);
            end
         end
         Done: begin
            if (bus.outReady) begin
               stateD = Idle;
            end
         end
         default: stateD = Idle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ <= Idle;
         countQ <= '0;
         accQ   <= '0;
         aQ     <= '0;
      end else begin
         stateQ <= stateD;
         countQ <= countD;
         accQ   <= accD;
         aQ     <= aD;
      end
   end

   assign bus.inReady  = (stateQ == Idle);
   assign bus.outValid = (stateQ == Done);
   assign bus.product  = accQ;
   assign busy         = (stateQ == Run);

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Scoreboard bench for seq_mult_ctrl: accepted operand pairs push A*B into a
// queue; a monitor compares the offered product and pops on handshake.
module tb_seq_mult_ctrl;
   import mult_pkg::*;

   localparam int unsigned N  = MULT_N;
   localparam int unsigned PW = 2 * N;
   typedef logic [PW-1:0] prodT;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic busy;

   seq_mult_ctrl_if #(.N(N)) bus ();

   seq_mult_ctrl #(
      .N (N)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .busy  (busy)
   );

   // Period well above the row ripple settle time.
   always #100 clk = ~clk;

   int      passCnt   = 0;
   int      totalCnt  = 0;
   longint  cyc       = 0;
   longint  acceptCyc = 0;
   logic    prevOutValid = 1'b0;
   prodT    expQ[$];
   logic    randReady  = 1'b0;
   logic    forceReady = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      bus.outReady = randReady ? ($urandom_range(0, 2) != 0) : forceReady;
   end

   task automatic check(input string name, input longint got, input longint exp);
      totalCnt++;
      if (got == exp) passCnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
   endtask

   // Monitor / scoreboard.
   always @(negedge clk) begin
      if (reset) begin
         expQ.delete();
         prevOutValid = 1'b0;
      end else begin
         if (bus.inValid && bus.inReady) begin
            expQ.push_back(prodT'(bus.multiplicand) * prodT'(bus.multiplier));
            acceptCyc = cyc + 1;
         end
         if (busy) begin
            check("inReady low while busy", longint'(bus.inReady), 0);
            check("outValid low while busy", longint'(bus.outValid), 0);
         end
         if (bus.outValid) begin
            if (!prevOutValid) check("latency", cyc - acceptCyc, longint'(N));
            check("inReady low while product held", longint'(bus.inReady), 0);
            if (expQ.size() == 0) begin
               totalCnt++;
               $display("FAIL outValid without accept: product %0d", bus.product);
            end else begin
               check("product", longint'(bus.product), longint'(expQ[0]));
               if (bus.outReady) void'(expQ.pop_front());
            end
         end
         prevOutValid = bus.outValid;
      end
   end

   task automatic send(input logic [N-1:0] a, input logic [N-1:0] b);
      int t;
      t = 0;
      @(posedge clk);
      #1;
      bus.inValid      = 1'b1;
      bus.multiplicand = a;
      bus.multiplier   = b;
      do begin
         @(negedge clk);
         t++;
      end while (!bus.inReady && t < 200);
      if (!bus.inReady) begin
         totalCnt++;
         $display("FAIL send timeout: inReady %0d, required 1", bus.inReady);
      end
      @(posedge clk);
      #1;
      bus.inValid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((expQ.size() != 0 || bus.outValid) && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (t >= 400) begin
         totalCnt++;
         $display("FAIL drain timeout: pending %0d, required 0", expQ.size());
      end
   endtask

   initial begin
      bus.inValid      = 1'b0;
      bus.multiplicand = '0;
      bus.multiplier   = '0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset inReady", longint'(bus.inReady), 1);
      check("reset outValid", longint'(bus.outValid), 0);
      check("reset busy", longint'(busy), 0);
      check("reset product", longint'(bus.product), 0);

      // Directed products.
      send(8'd13, 8'd11);
      drain();
      check("idle after handshake", longint'(bus.inReady), 1);
      send(8'd255, 8'd255);
      drain();
      send(8'd0, 8'd200);
      drain();
      send(8'd1, 8'd128);
      drain();

      // Backpressure: product must hold while outReady is low.
      forceReady = 1'b0;
      send(8'd6, 8'd7);
      begin
         int t;
         t = 0;
         while (!bus.outValid && t < 50) begin
            @(negedge clk);
            t++;
         end
      end
      repeat (5) begin
         @(negedge clk);
         check("outValid held under stall", longint'(bus.outValid), 1);
      end
      forceReady = 1'b1;
      drain();
      check("idle after stall release", longint'(bus.inReady), 1);

      // New operands offered mid-run are taken only once back in Idle.
      send(8'd3, 8'd5);
      repeat (3) @(posedge clk);
      send(8'd9, 8'd9);
      drain();

      // Reset in the middle of a run.
      send(8'd100, 8'd100);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("mid-run reset inReady", longint'(bus.inReady), 1);
      check("mid-run reset outValid", longint'(bus.outValid), 0);
      check("mid-run reset product", longint'(bus.product), 0);
      check("mid-run reset busy", longint'(busy), 0);
      send(8'd2, 8'd3);
      drain();

      // Random back-to-back traffic with random consumer stalls.
      randReady = 1'b1;
      for (int i = 0; i < 50; i++) begin
         logic [N-1:0] a;
         logic [N-1:0] b;
         a = N'($urandom_range(0, (1 << N) - 1));
         b = N'($urandom_range(0, (1 << N) - 1));
         send(a, b);
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      drain();
      check("scoreboard empty at end", longint'(expQ.size()), 0);

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
